// File: rtl/matrix_result_serializer.sv
// Serializes a 2x2 signed result matrix into four narrow elements (c00,c01,c10,c11) with optional ReLU and signed saturation.
// Latency: element 0 valid one cycle after capture; back-to-back matrices stream with no gap. Backpressure: out_ready low holds the element; in_ready follows out_ready on the last element. Optional ReLU: define MATMUL_SER_RELU_EN.
module matrix_result_serializer #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  c00,
    input  logic [IN_W-1:0]  c01,
    input  logic [IN_W-1:0]  c10,
    input  logic [IN_W-1:0]  c11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             out_sat,
    output logic [15:0]      sat_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t            state;
    logic [1:0]        idx;
    logic [IN_W-1:0]   hold [4];
    logic [IN_W-1:0]   elem;
    logic [IN_W-OUT_W:0] upper;
    logic              accept_in;
    logic              xfer;

    assign in_ready  = !rst && ((state == IDLE) || (idx == 2'd3 && out_ready));
    assign accept_in = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    assign out_idx  = idx;
    assign out_last = (idx == 2'd3);

    // Output element is a mux of the hold registers: no extra pipeline stage.
    always_comb begin
        elem = hold[idx];
`ifdef MATMUL_SER_RELU_EN
        if (elem[IN_W-1]) begin
            elem = '0;
        end
`endif
        upper    = elem[IN_W-1:OUT_W-1];
        out_data = elem[OUT_W-1:0];
        out_sat  = 1'b0;
        // In range exactly when every bit from the output sign bit upward agrees.
        if (!((&upper) || !(|upper))) begin
            out_sat  = 1'b1;
            out_data = elem[IN_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sat_cnt   <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
            end
        end else begin
            if (xfer && out_sat && sat_cnt != 16'hFFFF) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (accept_in) begin
                        hold[0]   <= c00;
                        hold[1]   <= c01;
                        hold[2]   <= c10;
                        hold[3]   <= c11;
                        idx       <= 2'd0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx != 2'd3) begin
                            idx <= idx + 2'd1;
                        end else if (accept_in) begin
                            hold[0] <= c00;
                            hold[1] <= c01;
                            hold[2] <= c10;
                            hold[3] <= c11;
                            idx     <= 2'd0;
                        end else begin
                            idx       <= 2'd0;
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= 2'd0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer (IN_W=128, OUT_W=64); expectations follow MATMUL_SER_RELU_EN.
module tb_matrix_result_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] c00, c01, c10, c11;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         out_sat;
    logic [15:0]  sat_cnt;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    logic [127:0] a_in  [4];
    logic [63:0]  a_exp [4];
    logic         a_sat [4];
    logic [127:0] b_in  [4];
    logic [63:0]  b_exp [4];
    logic         b_sat [4];

    matrix_result_serializer #(.IN_W(128), .OUT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive_a();
        in_valid = 1'b1;
        c00 = a_in[0]; c01 = a_in[1]; c10 = a_in[2]; c11 = a_in[3];
    endtask

    task automatic drive_b();
        in_valid = 1'b1;
        c00 = b_in[0]; c01 = b_in[1]; c10 = b_in[2]; c11 = b_in[3];
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_idx !== 2'd0 || out_last !== 1'b0 || out_sat !== 1'b0) begin errors++; $display("FAIL rst_tags got=%0d/%b/%b exp=0/0/0", out_idx, out_last, out_sat); end
        checks++; if (sat_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_cnt_busy got=%0d/%b exp=0/0", sat_cnt, busy); end
    endtask

    task automatic test_mixed();
        @(negedge clk);
        out_ready = 1'b1;
        drive_a();
        @(posedge clk);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mixed_valid e=%0d got=%b exp=1", e, out_valid); end
            checks++; if (out_data !== a_exp[e]) begin errors++; $display("FAIL mixed_data e=%0d got=%h exp=%h", e, out_data, a_exp[e]); end
            checks++; if (out_idx !== 2'(e) || out_last !== (e == 3)) begin errors++; $display("FAIL mixed_idx e=%0d got=%0d/%b", e, out_idx, out_last); end
            checks++; if (out_sat !== a_sat[e]) begin errors++; $display("FAIL mixed_sat e=%0d got=%b exp=%b", e, out_sat, a_sat[e]); end
            if (a_sat[e]) exp_cnt++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mixed_idle got=%b/%b exp=0/0", out_valid, busy); end
`ifdef MATMUL_SER_RELU_EN
        checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL mixed_satcnt got=%0d exp=1", sat_cnt); end
`else
        checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL mixed_satcnt got=%0d exp=2", sat_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_a();
        @(posedge clk);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (e == 1) begin
                for (int s = 0; s < 3; s++) begin
                    out_ready = 1'b0;
                    #1;
                    checks++; if (out_idx !== 2'd1 || out_data !== a_exp[1]) begin errors++; $display("FAIL bp_hold s=%0d got=%0d/%h exp=1/%h", s, out_idx, out_data, a_exp[1]); end
                    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_ctrl s=%0d got=%b/%b exp=0/1", s, in_ready, out_valid); end
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            #1;
            checks++; if (out_idx !== 2'(e) || out_data !== a_exp[e] || out_sat !== a_sat[e]) begin errors++; $display("FAIL bp_elem e=%0d got=%0d/%h/%b exp=%h", e, out_idx, out_data, out_sat, a_exp[e]); end
            checks++; if (in_ready !== (e == 3)) begin errors++; $display("FAIL bp_in_ready e=%0d got=%b", e, in_ready); end
            if (a_sat[e]) exp_cnt++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || sat_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_end got=%b/%0d exp=0/%0d", out_valid, sat_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_a();
        @(posedge clk);
        @(negedge clk);
        drive_b();
        for (int e = 0; e < 4; e++) begin
            if (e > 0) @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_idx !== 2'(e) || out_data !== a_exp[e]) begin errors++; $display("FAIL b2b_a e=%0d got=%b/%0d/%h exp=%h", e, out_valid, out_idx, out_data, a_exp[e]); end
            checks++; if (in_ready !== (e == 3)) begin errors++; $display("FAIL b2b_in_ready e=%0d got=%b", e, in_ready); end
            if (a_sat[e]) exp_cnt++;
            @(posedge clk);
        end
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_idx !== 2'(e) || out_last !== (e == 3)) begin errors++; $display("FAIL b2b_b_ctrl e=%0d got=%b/%0d/%b", e, out_valid, out_idx, out_last); end
            checks++; if (out_data !== b_exp[e] || out_sat !== b_sat[e]) begin errors++; $display("FAIL b2b_b_data e=%0d got=%h/%b exp=%h/%b", e, out_data, out_sat, b_exp[e], b_sat[e]); end
            if (b_sat[e]) exp_cnt++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || sat_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_end got=%b/%0d exp=0/%0d", out_valid, sat_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_a();
        @(posedge clk);
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_idx !== 2'(e) || out_data !== a_exp[e]) begin errors++; $display("FAIL rmid_pre e=%0d got=%0d/%h", e, out_idx, out_data); end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || sat_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abort got=%b/%0d/%b exp=0/0/0", out_valid, sat_cnt, busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        exp_cnt = 0;
        drive_b();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%b exp=1", in_ready); end
        @(posedge clk);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_idx !== 2'(e) || out_data !== b_exp[e]) begin errors++; $display("FAIL rmid_new e=%0d got=%b/%0d/%h exp=%h", e, out_valid, out_idx, out_data, b_exp[e]); end
            if (b_sat[e]) exp_cnt++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (sat_cnt !== 16'(exp_cnt) || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_end got=%0d/%b exp=%0d/0", sat_cnt, out_valid, exp_cnt); end
    endtask

    initial begin
        a_in[0] = 128'd5;
        a_in[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD;
        a_in[2] = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        a_in[3] = 128'hFFFF_FFFF_FFFF_FFC0_0000_0000_0000_0000;
`ifdef MATMUL_SER_RELU_EN
        a_exp[0] = 64'd5;  a_exp[1] = 64'd0;
        a_exp[2] = 64'h7FFF_FFFF_FFFF_FFFF; a_exp[3] = 64'd0;
        a_sat[0] = 1'b0; a_sat[1] = 1'b0; a_sat[2] = 1'b1; a_sat[3] = 1'b0;
`else
        a_exp[0] = 64'd5;  a_exp[1] = 64'hFFFF_FFFF_FFFF_FFFD;
        a_exp[2] = 64'h7FFF_FFFF_FFFF_FFFF; a_exp[3] = 64'h8000_0000_0000_0000;
        a_sat[0] = 1'b0; a_sat[1] = 1'b0; a_sat[2] = 1'b1; a_sat[3] = 1'b1;
`endif
        b_in[0] = 128'd10; b_in[1] = 128'd20; b_in[2] = 128'd30;
        b_in[3] = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
        b_exp[0] = 64'd10; b_exp[1] = 64'd20; b_exp[2] = 64'd30;
        b_exp[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        b_sat[0] = 1'b0; b_sat[1] = 1'b0; b_sat[2] = 1'b0; b_sat[3] = 1'b1;

        test_reset();
        test_mixed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matrix_result_serializer.md
# matrix_result_serializer

- Consumes one 2x2 result matrix (four parallel signed elements `c00`..`c11`) from the matrix multiplier through a valid/ready handshake.
- Emits the four elements one per transfer on a narrower valid/ready stream, in order `c00`, `c01`, `c10`, `c11`, each tagged with its index and an end-of-matrix marker.
- Each element passes through an optional ReLU stage, then signed saturation to the output width, and saturation events are counted.
- Sits between the matrix-multiply datapath and downstream storage/transport.

## Interface

Parameters:
- `IN_W`, default 128: width of each input matrix element (signed two's complement).
- `OUT_W`, default 64: width of the output element. Must satisfy 2 <= `OUT_W` <= `IN_W`.

Ports:
- `clk`  in  1  clock, all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input matrix present.
- `in_ready`  out  1  block can accept a matrix.
- `c00`, `c01`, `c10`, `c11`  in  `IN_W` each  result elements.
- `out_valid`  out  1  output element present.
- `out_ready`  in  1  downstream accepts the element.
- `out_data`  out  `OUT_W`  processed element.
- `out_idx`  out  2  element index: 0=`c00`, 1=`c01`, 2=`c10`, 3=`c11`.
- `out_last`  out  1  high when `out_idx`==3.
- `out_sat`  out  1  `out_data` was saturated.
- `sat_cnt`  out  16  saturated elements emitted since reset; sticks at 0xFFFF.
- `busy`  out  1  high in SEND.

## Operation

- FSM states: IDLE, SEND.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `c00`..`c11` into hold registers, set `idx`=0, go to SEND.
- **SEND**
  - `out_valid`=1. `out_data`/`out_sat` are derived from `hold[idx]`. `out_idx`=`idx`.
  - On `out_valid`&&`out_ready` with `idx`<3: `idx`+1.
  - On `out_valid`&&`out_ready` with `idx`==3, and `in_valid` high: capture the new matrix, `idx`=0, stay in SEND.
  - On `out_valid`&&`out_ready` with `idx`==3, and `in_valid` low: go to IDLE.
- `in_ready` = (state==IDLE) || (state==SEND && `idx`==3 && `out_ready`). This is a combinational path from `out_ready`. `in_ready` is 0 while `rst` is high.
- **Element processing**, applied to each `hold[idx]` in order:
  1. ReLU, if compiled in (see Configuration).
  2. Signed saturation:
     - value > 2^(`OUT_W`-1)-1 → 2^(`OUT_W`-1)-1, `out_sat`=1.
     - value < -2^(`OUT_W`-1) → -2^(`OUT_W`-1), `out_sat`=1.
     - Otherwise the low `OUT_W` bits, `out_sat`=0.
  - When `OUT_W`==`IN_W`, `out_sat` is constant 0.
- `sat_cnt` increments on each accepted transfer (`out_valid`&&`out_ready`) with `out_sat`=1. It does not wrap.
- While `out_valid`&&!`out_ready`, `out_data`, `out_idx`, `out_last` and `out_sat` are held stable.
- Input signals are ignored when `in_ready`=0.

## Timing

- Reset values: state IDLE, `idx`=0, hold registers 0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `out_sat`=0, `sat_cnt`=0, `busy`=0.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: a matrix accepted at edge N has element 0 valid in cycle N+1.
- Throughput: with `out_ready` held high, 4 cycles per matrix with no gaps between matrices.
- `rst` asserted mid-matrix aborts at the next edge. Remaining elements are discarded and no partial `out_last` is emitted.
- `out_data` is a registered-state mux. There is no additional pipeline register.

## Configuration

- Macro: `MATMUL_SER_RELU_EN`.
- Defined: an element with bit `IN_W`-1 set is replaced by 0 before saturation. Negative saturation therefore never occurs.
- Undefined: elements pass to saturation unchanged, as signed values.

## Test plan

All scenarios use `OUT_W`=64, `IN_W`=128.

- **Mixed values, ReLU off.** Matrix `c00`=5, `c01`=-3, `c10`=2^64, `c11`=-2^70; `out_ready`=1.
  - Outputs 5, 0xFFFF_FFFF_FFFF_FFFD, 0x7FFF_FFFF_FFFF_FFFF (sat), 0x8000_0000_0000_0000 (sat).
  - `out_idx` 0..3; `out_last` only on the 4th; `sat_cnt`=2.
- **Same matrix, `MATMUL_SER_RELU_EN` defined.** Outputs 5, 0, 0x7FFF_FFFF_FFFF_FFFF (sat), 0; `sat_cnt`=1.
- **Backpressure.** Drop `out_ready` for 3 cycles while `out_idx`=1.
  - `out_data`/`out_idx` held stable.
  - No element skipped or duplicated.
  - `in_ready`=0 throughout.
- **Back-to-back.** Two matrices, `in_valid` held high, `out_ready`=1.
  - 8 consecutive transfers with no bubble.
  - Second matrix accepted on the edge of the first matrix's `out_last` transfer.
- **Reset mid-operation.** Assert `rst` after 2 transfers.
  - Next cycle: `out_valid`=0, `sat_cnt`=0, state IDLE.
  - A new matrix then emits starting from `out_idx`=0.
